// File: rtl/sh7034_pkg.sv
// sh7034_pkg -- shared SCI types and constants for the SH7034 serial channels.
package sh7034_pkg;

  // Receive FSM states. MPBIT is only reachable in multiprocessor builds.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    MPBIT = 3'd4,
    STOP  = 3'd5
  } SCI_RX_STATE_t;

  // Serial mode register image: C/A, CHR, PE, O/E, STOP, MP, CKS[1:0].
  typedef struct packed {
    logic       ca;
    logic       chr;
    logic       pe;
    logic       oe;
    logic       stop;
    logic       mp;
    logic [1:0] cks;
  } SMR_t;

  // 16x oversampling phase at which each bit is sampled (mid-bit).
  localparam logic [3:0] SCI_OS_SAMPLE = 4'd7;

  // Prescaler divide per CKS setting, indexed by CKS.
  localparam logic [3:0][8:0] SCI_CKS_DIV = {9'd256, 9'd64, 9'd16, 9'd4};

endpackage

// File: rtl/sh7034_sci_baudgen.sv
// sh7034_sci_baudgen -- CE prescaler (/4*4^CKS) followed by the BRR divider
// (/N+1), producing a one-cycle 16x bit-rate tick. clr restarts both counters
// so the receiver can phase-align the tick to a start edge.
module sh7034_sci_baudgen
  import sh7034_pkg::*;
(
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       ce,
  input  logic [1:0] cks,
  input  logic [7:0] brr,
  input  logic       clr,
  output logic       tick
);

  logic [7:0] pre_cnt;
  logic [7:0] brr_cnt;
  logic [8:0] pre_div;
  logic       pre_wrap;
  logic       brr_wrap;

  // >= rather than == so a divisor shrinking mid-count cannot strand a counter
  assign pre_div  = SCI_CKS_DIV[cks];
  assign pre_wrap = ({1'b0, pre_cnt} >= (pre_div - 9'd1));
  assign brr_wrap = (brr_cnt >= brr);
  assign tick     = ce & pre_wrap & brr_wrap & ~clr;

  // prescaler and BRR counters, advanced only on CE
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      pre_cnt <= '0;
      brr_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
      brr_cnt <= '0;
    end else if (ce) begin
      if (pre_wrap) begin
        pre_cnt <= '0;
        brr_cnt <= brr_wrap ? 8'd0 : brr_cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sh7034_sci_rx.sv
// sh7034_sci_rx -- SCI asynchronous receiver: RXD -> RDR plus RDRF/ORER/FER/
// PER/MPB status. Define SCI_MP_EN to build in the multiprocessor format
// (MPBIT state, MPB flag, MPIE filtering, MPIE_CLR pulse).
module sh7034_sci_rx
  import sh7034_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       RXD,
  input  SMR_t       SMR,
  input  logic [7:0] BRR,
  input  logic       RE,
  input  logic       RIE,
  input  logic       MPIE,
  input  logic       RDRF_CLR,
  input  logic       ORER_CLR,
  input  logic       FER_CLR,
  input  logic       PER_CLR,
  output logic [7:0] RDR,
  output logic       RDRF,
  output logic       ORER,
  output logic       FER,
  output logic       PER,
  output logic       MPB,
  output logic       MPIE_CLR,
  output logic       RXI,
  output logic       ERI
);

`ifdef SCI_MP_EN
  localparam bit MP_EN = 1'b1;
`else
  localparam bit MP_EN = 1'b0;
`endif

  SCI_RX_STATE_t state, state_nx;
  logic [1:0] rx_sync;
  logic       rxs, rxs_d, fall;
  logic       tick, samp;
  logic [3:0] phase;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic       par_bit, mpb_bit;
  logic       err_any, start_det, last_bit, use_mp, use_par;
  logic       restart, bit_we, par_we, done;
  logic       mp_hit, discard, load, par_bad;
  logic       rdrf_set, orer_set, fer_set, per_set;
  logic       unused_smr;

  assign unused_smr = SMR.ca ^ SMR.stop;   // C/A and second stop bit do not affect receive

  assign rxs       = rx_sync[1];
  assign fall      = rxs_d & ~rxs;
  assign err_any   = ORER | FER | PER;
  assign start_det = RE & ~err_any & fall;
  assign samp      = tick & (phase == SCI_OS_SAMPLE);
  assign last_bit  = (bit_cnt == (SMR.chr ? 3'd6 : 3'd7));
  assign use_mp    = MP_EN & SMR.mp;
  assign use_par   = SMR.pe & ~use_mp;

  sh7034_sci_baudgen u_baud (
    .gclk   (CLK),
    .grst_n (RST_N),
    .ce     (CE),
    .cks    (SMR.cks),
    .brr    (BRR),
    .clr    (restart),
    .tick   (tick)
  );

  // 2-FF synchroniser plus delayed copy for falling-edge detect; idles high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_sync <= 2'b11;
      rxs_d   <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], RXD};
      rxs_d   <= rxs;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state; RE=0 drops any frame in progress
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_det) state_nx = START;
      START: if (samp) state_nx = rxs ? IDLE : DATA;
      DATA:  if (samp && last_bit) state_nx = use_mp ? MPBIT : (use_par ? PAR : STOP);
      PAR:   if (samp) state_nx = STOP;
      MPBIT: if (samp) state_nx = STOP;
      STOP:  if (samp) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (!RE) state_nx = IDLE;
  end

  // FSM outputs: per-state sample strobes and frame restart
  always_comb begin
    restart = 1'b0;
    bit_we  = 1'b0;
    par_we  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:  restart = start_det;
      DATA:  bit_we  = samp;
      PAR:   par_we  = samp;
      STOP:  done    = samp & RE;
      default: ;
    endcase
  end

  // oversampling phase, data shifter and parity capture
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase   <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par_bit <= 1'b0;
    end else if (restart) begin
      phase   <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par_bit <= 1'b0;
    end else begin
      if (tick)   phase <= phase + 4'd1;
      if (bit_we) begin
        sh[bit_cnt] <= rxs;
        bit_cnt     <= bit_cnt + 3'd1;
      end
      if (par_we) par_bit <= rxs;
    end
  end

  // Frame completion. MPIE with a data frame (MPB=0) discards the frame;
  // overrun keeps the old RDR and reports nothing else.
  assign mp_hit   = MP_EN & SMR.mp & MPIE;
  assign discard  = mp_hit & ~mpb_bit;
  assign load     = done & ~discard & ~RDRF;
  assign orer_set = done & ~discard & RDRF;
  assign par_bad  = use_par & (par_bit != ((^sh) ^ SMR.oe));
  assign fer_set  = load & ~rxs;
  assign per_set  = load & par_bad;
  assign rdrf_set = load & rxs & ~par_bad;

  // status flags and RDR; a set beats a same-cycle clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RDR  <= '0;
      RDRF <= 1'b0;
      ORER <= 1'b0;
      FER  <= 1'b0;
      PER  <= 1'b0;
    end else begin
      RDRF <= rdrf_set | (RDRF & ~RDRF_CLR);
      ORER <= orer_set | (ORER & ~ORER_CLR);
      FER  <= fer_set  | (FER  & ~FER_CLR);
      PER  <= per_set  | (PER  & ~PER_CLR);
      if (load) RDR <= sh;
    end
  end

`ifdef SCI_MP_EN
  // multiprocessor bit capture, MPB flag and MPIE clear pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mpb_bit  <= 1'b0;
      MPB      <= 1'b0;
      MPIE_CLR <= 1'b0;
    end else begin
      if (restart)                    mpb_bit <= 1'b0;
      else if (samp && state == MPBIT) mpb_bit <= rxs;
      if (load) MPB <= mpb_bit;
      MPIE_CLR <= done & mp_hit & mpb_bit;
    end
  end
`else
  assign mpb_bit  = 1'b0;
  assign MPB      = 1'b0;
  assign MPIE_CLR = 1'b0;
`endif

  assign RXI = RIE & RDRF;
  assign ERI = RIE & err_any;

endmodule

// File: tb/tb_sh7034_sci_rx.sv
// tb_sh7034_sci_rx -- randomized frames against a frame-level reference model.
module tb_sh7034_sci_rx;

`ifdef SCI_MP_EN
  localparam bit MP_ON = 1'b1;
`else
  localparam bit MP_ON = 1'b0;
`endif

  logic       CLK = 1'b0, RST_N = 1'b0, CE = 1'b1, RXD = 1'b1;
  logic [7:0] SMR = 8'h00, BRR = 8'h00;
  logic       RE = 1'b0, RIE = 1'b0, MPIE = 1'b0;
  logic       RDRF_CLR = 1'b0, ORER_CLR = 1'b0, FER_CLR = 1'b0, PER_CLR = 1'b0;
  logic [7:0] RDR;
  logic       RDRF, ORER, FER, PER, MPB, MPIE_CLR, RXI, ERI;

  int vectors = 0, miscompares = 0, mon_pulses = 0;

  // configuration and reference-model state
  logic       chr, pe, oe, mp, ce_rand;
  logic [1:0] cks;
  logic [7:0] brr;
  int         bit_ce;
  logic [7:0] m_rdr;
  logic       m_rdrf, m_orer, m_fer, m_per, m_mpb;
  int         m_pulses = 0;

  sh7034_sci_rx dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .RXD(RXD), .SMR(SMR), .BRR(BRR),
    .RE(RE), .RIE(RIE), .MPIE(MPIE),
    .RDRF_CLR(RDRF_CLR), .ORER_CLR(ORER_CLR), .FER_CLR(FER_CLR), .PER_CLR(PER_CLR),
    .RDR(RDR), .RDRF(RDRF), .ORER(ORER), .FER(FER), .PER(PER), .MPB(MPB),
    .MPIE_CLR(MPIE_CLR), .RXI(RXI), .ERI(ERI)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (MPIE_CLR === 1'b1) mon_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/RDR"},  RDR,  m_rdr);
    chk({tag, "/RDRF"}, RDRF, m_rdrf);
    chk({tag, "/ORER"}, ORER, m_orer);
    chk({tag, "/FER"},  FER,  m_fer);
    chk({tag, "/PER"},  PER,  m_per);
    chk({tag, "/MPB"},  MPB,  m_mpb);
    chk({tag, "/RXI"},  RXI,  RIE & m_rdrf);
    chk({tag, "/ERI"},  ERI,  RIE & (m_orer | m_fer | m_per));
    chk({tag, "/MPIE_CLR_cnt"}, mon_pulses, m_pulses);
  endtask

  task automatic model_reset();
    m_rdr = 8'h00; m_rdrf = 0; m_orer = 0; m_fer = 0; m_per = 0; m_mpb = 0;
  endtask

  task automatic cyc();
    @(negedge CLK);
    CE = ce_rand ? ($urandom_range(3) != 0) : 1'b1;
  endtask

  task automatic hold_bit(input bit b);
    int n = 0;
    RXD = b;
    while (n < bit_ce) begin
      cyc();
      if (CE) n++;
    end
  endtask

  task automatic set_cfg(input logic c_chr, input logic c_pe, input logic c_oe,
                         input logic c_mp, input logic [1:0] c_cks, input logic [7:0] c_brr);
    chr = c_chr; pe = c_pe; oe = c_oe; mp = c_mp; cks = c_cks; brr = c_brr;
    SMR = {1'($urandom_range(1)), chr, pe, oe, 1'($urandom_range(1)), mp, cks};
    BRR = brr;
    bit_ce = (64 << (2 * int'(cks))) * (int'(brr) + 1);
  endtask

  task automatic pulse_clr(input logic r, input logic o, input logic f, input logic p);
    RDRF_CLR = r; ORER_CLR = o; FER_CLR = f; PER_CLR = p;
    cyc();
    RDRF_CLR = 0; ORER_CLR = 0; FER_CLR = 0; PER_CLR = 0;
    if (r) m_rdrf = 0;
    if (o) m_orer = 0;
    if (f) m_fer = 0;
    if (p) m_per = 0;
  endtask

  // abort_kind: 1 = drop RE, 2 = assert reset, before frame bit abort_at
  task automatic send_frame(input string tag, input logic [7:0] d, input bit stop_b,
                            input bit par_flip, input bit mpb_b,
                            input int abort_at, input int abort_kind);
    bit q[$];
    logic [7:0] dm;
    int nb, ones;
    bit mp_on, live, perr, par_b, aborted;
    dm    = chr ? {1'b0, d[6:0]} : d;
    nb    = chr ? 7 : 8;
    ones  = $countones(dm);
    mp_on = MP_ON && mp;
    par_b = ((ones % 2) != 0) ^ oe ^ par_flip;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) q.push_back(dm[i]);
    if (mp_on)   q.push_back(mpb_b);
    else if (pe) q.push_back(par_b);
    q.push_back(stop_b);
    live    = RE && !(m_orer || m_fer || m_per);
    aborted = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        aborted = 1;
        if (abort_kind == 1) RE = 1'b0;
        else begin
          RST_N = 1'b0;
          MPIE  = 1'b0;
          #1;
          model_reset();
          check_all({tag, "/in_reset"});
          chk({tag, "/in_reset/MPIE_CLR"}, MPIE_CLR, 0);
        end
      end
      hold_bit(q[i]);
    end
    hold_bit(1'b1);
    if (aborted) begin
      RE    = 1'b1;
      RST_N = 1'b1;
      repeat (3) cyc();
    end else if (live && !(mp_on && MPIE && !mpb_b)) begin
      if (mp_on && MPIE) begin
        m_pulses++;
        MPIE = 1'b0;
      end
      if (m_rdrf) m_orer = 1;
      else begin
        perr  = !mp_on && pe && (((ones + int'(par_b)) % 2) != int'(oe));
        m_rdr = dm;
        m_mpb = mp_on ? mpb_b : 1'b0;
        if (!stop_b) m_fer = 1;
        if (perr) m_per = 1;
        if (stop_b && !perr) m_rdrf = 1;
      end
    end
    check_all(tag);
  endtask

  initial begin
    ce_rand = 0;
    model_reset();
    set_cfg(0, 0, 0, 0, 2'd0, 8'd0);
    repeat (4) cyc();
    check_all("reset");
    chk("reset/MPIE_CLR", MPIE_CLR, 0);
    RST_N = 1'b1; RE = 1'b1; RIE = 1'b1;
    repeat (4) cyc();

    // basic 8N1 reception
    send_frame("t1_a5", 8'hA5, 1, 0, 0, -1, 0);
    // parity error blocks following frames until cleared
    pulse_clr(1, 0, 0, 0);
    set_cfg(0, 1, 0, 0, 2'd0, 8'd0);
    send_frame("t2_per", 8'h01, 1, 1, 0, -1, 0);
    send_frame("t2_blocked", 8'h55, 1, 0, 0, -1, 0);
    pulse_clr(0, 0, 0, 1);
    send_frame("t2_after", 8'h02, 1, 0, 0, -1, 0);
    // odd parity, good
    pulse_clr(1, 0, 0, 0);
    set_cfg(0, 1, 1, 0, 2'd0, 8'd0);
    send_frame("odd_par", 8'h37, 1, 0, 0, -1, 0);
    // overrun
    pulse_clr(1, 0, 0, 0);
    set_cfg(0, 0, 0, 0, 2'd0, 8'd0);
    send_frame("t3_11", 8'h11, 1, 0, 0, -1, 0);
    send_frame("t3_22", 8'h22, 1, 0, 0, -1, 0);
    pulse_clr(1, 1, 0, 0);
    send_frame("t3_33", 8'h33, 1, 0, 0, -1, 0);
    // framing error, then a short glitch
    pulse_clr(1, 0, 0, 0);
    send_frame("t4_fer", 8'h5A, 0, 0, 0, -1, 0);
    pulse_clr(0, 0, 1, 0);
    RXD = 1'b0;
    repeat (6) cyc();
    hold_bit(1'b1);
    hold_bit(1'b1);
    check_all("t4_glitch");
    // 7-bit characters
    set_cfg(1, 0, 0, 0, 2'd0, 8'd0);
    send_frame("chr7", 8'hFF, 1, 0, 0, -1, 0);
    // multiprocessor: data frame filtered, ID frame accepted
    pulse_clr(1, 0, 0, 0);
    set_cfg(0, 0, 0, 1, 2'd0, 8'd0);
    MPIE = 1'b1;
    send_frame("t5_12", 8'h12, 1, 0, 0, -1, 0);
    send_frame("t5_34", 8'h34, 1, 0, 1, -1, 0);
    // reset mid-frame, then a clean frame
    pulse_clr(1, 1, 1, 1);
    set_cfg(0, 0, 0, 0, 2'd0, 8'd1);
    send_frame("t6_rst", 8'h6C, 1, 0, 0, 4, 2);
    send_frame("t6_after_rst", 8'h9D, 1, 0, 0, -1, 0);
    // RE drop mid-frame keeps flags
    send_frame("t6_re", 8'h4E, 1, 0, 0, 4, 1);
    pulse_clr(1, 0, 0, 0);
    send_frame("t6_after_re", 8'hC3, 1, 0, 0, -1, 0);
    // slower prescaler
    pulse_clr(1, 0, 0, 0);
    set_cfg(0, 0, 0, 0, 2'd1, 8'd0);
    send_frame("cks1", 8'h81, 1, 0, 0, -1, 0);

    for (int k = 0; k < 20; k++) begin
      logic [1:0] r_cks;
      ce_rand = 1'($urandom_range(1));
      r_cks   = ($urandom_range(7) == 0) ? 2'd1 : 2'd0;
      set_cfg(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              1'($urandom_range(1)), r_cks, (r_cks != 0) ? 8'd0 : 8'($urandom_range(1)));
      MPIE = 1'($urandom_range(1));
      RIE  = 1'($urandom_range(1));
      pulse_clr(1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), 1'($urandom_range(1)));
      send_frame("rand", 8'($urandom), $urandom_range(7) != 0,
                 pe ? ($urandom_range(3) == 0) : 1'b0, 1'($urandom_range(1)), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sh7034_sci_rx.md
# sh7034_sci_rx

Asynchronous receive channel of the SH7034 SCI: deserialises RXD into RDR and maintains the receive-side SSR flags (RDRF, ORER, FER, PER, MPB). It is the receiving end of the serial link whose transmit side is driven from TDR. It sits beside the SCI register block, which owns SMR, BRR and SCR and decodes the CPU's read-1-then-write-0 flag clears into clear pulses. One instance per channel (SCI0, SCI1).

## Interface
Parameters:
- none

Ports (clock and reset first):
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous and active-low
- CE  in  1  peripheral clock enable; φ tick
- RXD  in  1  serial input; asynchronous
- SMR  in  8  SMR_t (CHR, PE, OE, STOP, MP, CKS); CA ignored
- BRR  in  8  bit-rate value N
- RE  in  1  SCR.RE
- RIE  in  1  SCR.RIE
- MPIE  in  1  SCR.MPIE
- RDRF_CLR, ORER_CLR, FER_CLR, PER_CLR  in  1 each  one-cycle clear pulses
- RDR  out  8  receive data; reset 00h
- RDRF, ORER, FER, PER, MPB  out  1 each  flags; reset 0
- MPIE_CLR  out  1  one-cycle pulse that clears SCR.MPIE; reset 0
- RXI  out  1  RIE & RDRF; reset 0
- ERI  out  1  RIE & (ORER | FER | PER); reset 0

## Operation
- Baud tick (16× bit rate): prescaler ÷4·4^CKS (4/16/64/256 CE ticks), then ÷(N+1). Bit period is 64·4^CKS·(N+1) CE ticks.
- RXD is synchronised with a 2-FF chain. All sampling uses the synchronised signal.
- FSM states: IDLE, START, DATA, PAR, MPBIT, STOP.
- IDLE -> START: on a synchronised falling edge while RE=1 and ORER|FER|PER=0. The 16× phase counter restarts at the edge.
- START: sample at phase 7. If the sample is 1 (glitch), return to IDLE. If 0, go to DATA.
- DATA: 8 bits, or 7 when CHR=1. LSB first, one sample at phase 7 of each bit. With CHR=1, RDR[7]=0.
- PAR: entered only when PE=1 and MP=0. Expected parity is even when OE=0 and odd when OE=1.
- MPBIT: entered only when MP=1. When MP=1, PE is ignored.
- STOP: only the first stop bit is checked; STOP=1 (two stop bits) has no receive effect. The bit is sampled at phase 7 and the FSM then returns to IDLE.
- Frame completion, in priority order:
  - MPIE=1 and MPB bit=0: frame discarded, no flag or RDR change.
  - MPIE=1 and MPB bit=1: pulse MPIE_CLR, then process as a normal frame.
  - RDRF=1: set ORER; RDR is not updated.
  - Otherwise load RDR and MPB.
  - If the stop bit is 0, set FER. If parity is wrong, set PER. If neither error occurs, set RDRF.
  - If FER or PER is set, RDRF is unchanged.
- While any error flag is set, new start bits are ignored.
- RE=0: the FSM is forced to IDLE within one cycle and the frame in progress is dropped. Flags and RDR are kept.
- A flag set and its clear pulse in the same cycle: set wins.

## Timing
- Flags, RDR and MPIE_CLR update on the CLK edge after the stop-bit sample tick. Latency is 1 CLK.
- RXI and ERI are combinational from the registered flags.
- Falling-edge detection lags RXD by 2–3 CLK, due to the synchroniser.
- A clear pulse takes effect on the next CLK edge.
- Reset mid-frame: all state returns to IDLE and all outputs return to their reset values immediately (asynchronous).
- BRR or CKS changed mid-frame: the counters continue with the new divisors. Result is undefined for that frame, with no lock-up.

## Configuration
- SCI_MP_EN defined: multiprocessor format supported (MPBIT state, MPB flag, MPIE filtering, MPIE_CLR).
- SCI_MP_EN undefined:
  - MP and MPIE are ignored and the MPBIT state is absent.
  - MPB and MPIE_CLR are tied to 0.
  - PE and OE are always honoured.

## Structure
- SH7034_PKG gains:
  - SCI_RX_STATE_t enum (the six states).
  - SCI_OS_SAMPLE = 7 (mid-bit phase).
  - SCI_CKS_DIV array (4, 16, 64, 256).
- Sub-module sh7034_sci_baudgen: prescaler, BRR counter and 16× tick output. It is shared with the future transmitter.

## Test plan
1. CKS=0, BRR=0, 8N1, RXD frame A5h -> RDR=A5h, RDRF=1, RXI=1 (RIE=1) 1 CLK after the stop sample. Bit time = 64 CE.
2. PE=1, OE=0, data 01h with parity bit 0 -> PER=1, RDR=01h, RDRF=0, ERI=1. A following frame is ignored until PER_CLR.
3. Two frames 11h then 22h with no RDRF_CLR -> RDR=11h, ORER=1. After ORER_CLR and RDRF_CLR, frame 33h -> RDR=33h.
4. Stop bit held 0 on frame 5Ah -> FER=1, RDR=5Ah, RDRF=0. Separately, a 6-tick low glitch on RXD -> no flag change.
5. SCI_MP_EN, MP=1, MPIE=1: frame 12h with MPB=0 -> no change. Frame 34h with MPB=1 -> RDR=34h, MPB=1, RDRF=1, MPIE_CLR pulse.
6. RST_N low during data bit 3, or RE=0 mid-frame -> FSM in IDLE. Reset clears all outputs; RE=0 keeps flags. The next full frame is received correctly.
